recovery_commit_drain: RTL and testbench
========================================

RECOVERY_COMMIT_DRAIN -- requirements
Module: recovery_commit_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of store-log entries (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter DW, default 32, meaning data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-006 SHALL have port recovery_mode  input  1  high while the cores replay under recovery.
REQ-007 SHALL have port log_we  input  1  voted store strobe during replay.
REQ-008 SHALL have port log_addr  input  AW  voted store address.
REQ-009 SHALL have port log_wdata  input  DW  voted store data.
REQ-010 SHALL have port replay_done  input  1  one-cycle pulse: replay reached checkpoint, commit log.
REQ-011 SHALL have port abort  input  1  one-cycle pulse: voter mismatch during replay, discard log.
REQ-012 SHALL have port rd_addr  input  AW  replay load address for forwarding.
REQ-013 SHALL have port rd_data  output  DW  forwarded load data.
REQ-014 SHALL have port rd_hit  output  1  rd_addr matches a valid log entry.
REQ-015 SHALL have port mem_we  output  1  commit write valid to data memory.
REQ-016 SHALL have port mem_addr  output  AW  commit address.
REQ-017 SHALL have port mem_wdata  output  DW  commit data.
REQ-018 SHALL have port mem_ready  input  1  data memory accepts commit write this cycle.
REQ-019 SHALL have port core_hold_req  output  1  hold cores while committing.
REQ-020 SHALL have port drain_done  output  1  one-cycle pulse: recovery commit finished.
REQ-021 SHALL have port commit_err  output  1  sticky: log overflowed, nothing committed.
REQ-022 SHALL have port log_count  output  clog2(DEPTH)+1  valid entries held.

Function
REQ-023 SHALL implement FSM IDLE, LOG, DRAIN, DONE.
REQ-024 IDLE: rising edge of recovery_mode (registered previous value) -> LOG; wr_ptr, rd_ptr, log_count cleared, commit_err cleared.
REQ-025 LOG: log_we with log_count<DEPTH -> entry {log_addr,log_wdata} written at wr_ptr, wr_ptr and log_count +1 next cycle.
REQ-026 LOG: log_we with log_count==DEPTH -> entry dropped, commit_err set, count unchanged.
REQ-027 LOG: abort -> IDLE, log_count cleared; abort has priority over log_we and replay_done in the same cycle.
REQ-028 LOG: replay_done with log_we same cycle -> store logged first, then included in drain.
REQ-029 LOG: replay_done -> DRAIN if log_count (after same-cycle write) >0 and commit_err=0; else DONE.
REQ-030 DRAIN: mem_we=1, mem_addr/mem_wdata = entry at rd_ptr, held stable until mem_ready=1.
REQ-031 DRAIN: mem_we && mem_ready -> rd_ptr +1, log_count -1; last entry accepted -> DONE.
REQ-032 Entries SHALL commit strictly in logged order; repeated addresses commit every write, last one wins.
REQ-033 DRAIN: log_we, abort, replay_done ignored.
REQ-034 core_hold_req SHALL be 1 exactly in DRAIN and DONE.
REQ-035 DONE: drain_done=1 for one cycle -> IDLE; commit_err retained until next LOG entry.
REQ-036 rd_hit/rd_data combinational over registered entries only, valid in LOG only; newest matching entry wins; no match or other state -> rd_hit=0, rd_data=0.
REQ-037 Pointers SHALL wrap modulo DEPTH.
REQ-038 recovery_mode falling in LOG without replay_done SHALL be treated as abort.

Reset
REQ-039 rst_in=1 at any clock edge, including mid-DRAIN -> state IDLE, pointers/log_count 0, commit_err 0, mem_we 0, core_hold_req 0, drain_done 0, rd_hit 0, rd_data 0; partial commits not resumed.

Verification
REQ-040 Log 3 stores (0x10=0xA, 0x14=0xB, 0x10=0xC), replay_done, mem_ready=1 -> mem writes 0x10/0xA, 0x14/0xB, 0x10/0xC on 3 consecutive cycles, then drain_done pulse, log_count 0.
REQ-041 mem_ready=0 for 4 cycles in DRAIN -> mem_we, mem_addr, mem_wdata unchanged, core_hold_req=1 throughout.
REQ-042 Log 9 stores with DEPTH=8 then replay_done -> no mem_we, drain_done pulse, commit_err=1, log_count 8 before DONE.
REQ-043 Log 2 stores, abort with replay_done same cycle -> IDLE, log_count 0, no mem_we, no drain_done.
REQ-044 Log 0x20=0x1 then 0x20=0x2, rd_addr=0x20 -> rd_hit=1, rd_data=0x2; rd_addr=0x24 -> rd_hit=0.
REQ-045 rst_in asserted after first of 3 commits accepted -> next cycle all outputs 0, IDLE; new recovery_mode rise starts empty log.

Source files
------------

// File: rtl/recovery_commit_drain.sv
// Recovery store log: buffers voted stores during replay, forwards them to replay loads,
// and drains them in order to data memory once replay reaches its checkpoint.
module recovery_commit_drain #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     recovery_mode,
  input  logic                     log_we,
  input  logic [AW-1:0]            log_addr,
  input  logic [DW-1:0]            log_wdata,
  input  logic                     replay_done,
  input  logic                     abort,
  input  logic [AW-1:0]            rd_addr,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_hit,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic                     core_hold_req,
  output logic                     drain_done,
  output logic                     commit_err,
  output logic [$clog2(DEPTH):0]   log_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StLog, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          rec_q;
  logic          log_write;
  logic [PW-1:0] fwd_idx;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_d         = err_q;
    log_write     = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    core_hold_req = 1'b0;
    drain_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (recovery_mode && !rec_q) begin
          state_d  = StLog;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
        end
      end
      StLog: begin
        // A dropped recovery_mode without a checkpoint discards the log like abort.
        if (abort || (!recovery_mode && !replay_done)) begin
          state_d  = StIdle;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (log_we) begin
            if (count_q < CW'(DEPTH)) begin
              log_write = 1'b1;
              wr_ptr_d  = wr_ptr_q + PW'(1);
              count_d   = count_q + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          if (replay_done) begin
            state_d = (count_d != '0 && !err_d) ? StDrain : StDone;
          end
        end
      end
      StDrain: begin
        core_hold_req = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = addr_mem[rd_ptr_q];
        mem_wdata     = data_mem[rd_ptr_q];
        if (mem_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = StDone;
        end
      end
      StDone: begin
        core_hold_req = 1'b1;
        drain_done    = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Oldest-to-newest scan so the newest matching entry overrides earlier ones.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    fwd_idx = '0;
    if (state_q == StLog) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fwd_idx = rd_ptr_q + PW'(i);
        if (CW'(i) < count_q && addr_mem[fwd_idx] == rd_addr) begin
          rd_hit  = 1'b1;
          rd_data = data_mem[fwd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      rec_q    <= recovery_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (log_write) begin
      addr_mem[wr_ptr_q] <= log_addr;
      data_mem[wr_ptr_q] <= log_wdata;
    end
  end

  assign log_count  = count_q;
  assign commit_err = err_q;

endmodule

// File: tb/tb_recovery_commit_drain.sv
// Self-checking bench for recovery_commit_drain: directed scenarios plus randomized
// replay sessions checked against a queue-based model of the store log.
module tb_recovery_commit_drain;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_in, recovery_mode, log_we, replay_done, abort, mem_ready;
  logic [AW-1:0] log_addr, rd_addr, mem_addr;
  logic [DW-1:0] log_wdata, rd_data, mem_wdata;
  logic          rd_hit, mem_we, core_hold_req, drain_done, commit_err;
  logic [3:0]    log_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc  [$];

  recovery_commit_drain #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_in(rst_in), .recovery_mode(recovery_mode), .log_we(log_we),
    .log_addr(log_addr), .log_wdata(log_wdata), .replay_done(replay_done), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .core_hold_req(core_hold_req), .drain_done(drain_done), .commit_err(commit_err),
    .log_count(log_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_log();
    recovery_mode = 1'b0;
    step();
    recovery_mode = 1'b1;
    step();
  endtask

  task automatic log_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    log_we = 1'b1; log_addr = a; log_wdata = d;
    step();
    log_we = 1'b0;
  endtask

  task automatic pulse_replay();
    replay_done = 1'b1;
    step();
    replay_done = 1'b0;
  endtask

  // Collects accepted memory writes until drain_done or the cycle budget runs out.
  task automatic run_drain(input int budget, input bit rand_ready, output bit done_seen);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (drain_done) begin
        done_seen = 1'b1;
        break;
      end
      mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_we && mem_ready) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
        obs_cyc.push_back(cycle);
      end
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step(); step();
    n_checks++;
    if ({mem_we, core_hold_req, drain_done, rd_hit, commit_err} !== 5'b0 ||
        log_count !== 4'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b hold=%b done=%b hit=%b err=%b cnt=%0d data=%h, want all 0",
               mem_we, core_hold_req, drain_done, rd_hit, commit_err, log_count, rd_data);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_basic_commit();
    logic [AW-1:0] ea [3] = '{32'h10, 32'h14, 32'h10};
    logic [DW-1:0] ed [3] = '{32'hA, 32'hB, 32'hC};
    bit done;
    enter_log();
    for (int i = 0; i < 3; i++) log_store(ea[i], ed[i]);
    n_checks++;
    if (log_count !== 4'd3) begin
      n_fail++; $display("FAIL basic_count: got %0d want 3", log_count);
    end
    pulse_replay();
    n_checks++;
    if (core_hold_req !== 1'b1) begin
      n_fail++; $display("FAIL basic_hold: got %b want 1", core_hold_req);
    end
    run_drain(20, 1'b0, done);
    n_checks++;
    if (obs_addr.size() != 3) begin
      n_fail++; $display("FAIL basic_nwrites: got %0d want 3", obs_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i] ||
            (i > 0 && obs_cyc[i] != obs_cyc[i-1] + 1)) begin
          n_fail++;
          $display("FAIL basic_write%0d: got %h/%h want %h/%h (consecutive)",
                   i, obs_addr[i], obs_data[i], ea[i], ed[i]);
        end
      end
    end
    n_checks++;
    if (!done || log_count !== 4'd0 || core_hold_req !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b cnt=%0d hold=%b want 1/0/1",
               done, log_count, core_hold_req);
    end
    step();
    n_checks++;
    if (drain_done !== 1'b0 || core_hold_req !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got done=%b hold=%b want 0/0", drain_done, core_hold_req);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    enter_log();
    log_store(32'h40, 32'h11);
    log_store(32'h44, 32'h22);
    pulse_replay();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h11 ||
          core_hold_req !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got we=%b %h/%h hold=%b want 1 40/11 1",
                 i, mem_we, mem_addr, mem_wdata, core_hold_req);
      end
      step();
    end
    run_drain(20, 1'b0, done);
    n_checks++;
    if (!done || obs_addr.size() != 2 || obs_addr[0] !== 32'h40 || obs_data[1] !== 32'h22) begin
      n_fail++;
      $display("FAIL stall_release: got done=%b n=%0d want done=1 n=2 40/11,44/22",
               done, obs_addr.size());
    end
    step();
  endtask

  task automatic test_overflow();
    bit done;
    enter_log();
    for (int i = 0; i < 9; i++) begin
      log_store(32'h200 + 32'(i * 4), 32'(i));
      if (i == 7) begin
        n_checks++;
        if (log_count !== 4'd8 || commit_err !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full: got cnt=%0d err=%b want 8/0", log_count, commit_err);
        end
      end
    end
    n_checks++;
    if (log_count !== 4'd8 || commit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: got cnt=%0d err=%b want 8/1", log_count, commit_err);
    end
    pulse_replay();
    run_drain(5, 1'b0, done);
    n_checks++;
    if (!done || obs_addr.size() != 0 || commit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_commit: got done=%b n=%0d err=%b want 1/0/1",
               done, obs_addr.size(), commit_err);
    end
    step();
    n_checks++;
    if (commit_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b want 1", commit_err);
    end
    enter_log();
    n_checks++;
    if (commit_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", commit_err);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    enter_log();
    log_store(32'h60, 32'h1);
    log_store(32'h64, 32'h2);
    abort = 1'b1; replay_done = 1'b1;
    step();
    abort = 1'b0; replay_done = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem_we !== 1'b0 || drain_done !== 1'b0 || core_hold_req !== 1'b0 ||
          log_count !== 4'd0) begin
        n_fail++;
        $display("FAIL abort_cycle%0d: got we=%b done=%b hold=%b cnt=%0d want 0/0/0/0",
                 i, mem_we, drain_done, core_hold_req, log_count);
      end
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_forward();
    enter_log();
    log_store(32'h20, 32'h1);
    log_store(32'h20, 32'h2);
    rd_addr = 32'h20; #1;
    n_checks++;
    if (rd_hit !== 1'b1 || rd_data !== 32'h2) begin
      n_fail++; $display("FAIL fwd_newest: got %b/%h want 1/2", rd_hit, rd_data);
    end
    rd_addr = 32'h24; #1;
    n_checks++;
    if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_miss: got %b/%h want 0/0", rd_hit, rd_data);
    end
    abort = 1'b1; step(); abort = 1'b0;
    rd_addr = 32'h20; #1;
    n_checks++;
    if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_idle: got %b/%h want 0/0", rd_hit, rd_data);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit done;
    enter_log();
    log_store(32'h80, 32'h5);
    log_store(32'h84, 32'h6);
    log_store(32'h88, 32'h7);
    pulse_replay();
    mem_ready = 1'b1;
    step();
    n_checks++;
    if (mem_addr !== 32'h84 || log_count !== 4'd2) begin
      n_fail++; $display("FAIL rst_mid_pre: got %h cnt=%0d want 84/2", mem_addr, log_count);
    end
    rst_in = 1'b1; recovery_mode = 1'b0;
    step();
    n_checks++;
    if ({mem_we, core_hold_req, drain_done, rd_hit, commit_err} !== 5'b0 ||
        log_count !== 4'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got we=%b hold=%b done=%b hit=%b err=%b cnt=%0d want all 0",
               mem_we, core_hold_req, drain_done, rd_hit, commit_err, log_count);
    end
    rst_in = 1'b0; mem_ready = 1'b0;
    step();
    n_checks++;
    if (mem_we !== 1'b0 || core_hold_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_resume: got we=%b hold=%b want 0/0", mem_we, core_hold_req);
    end
    enter_log();
    n_checks++;
    if (log_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_new_log: got cnt=%0d want 0", log_count);
    end
    log_store(32'h90, 32'h9);
    pulse_replay();
    run_drain(20, 1'b0, done);
    n_checks++;
    if (!done || obs_addr.size() != 1 || obs_addr[0] !== 32'h90 || obs_data[0] !== 32'h9) begin
      n_fail++;
      $display("FAIL rst_new_drain: got done=%b n=%0d want 1/1 90/9", done, obs_addr.size());
    end
    step();
  endtask

  task automatic test_random();
    logic [AW-1:0] mq_addr [$];
    logic [DW-1:0] mq_data [$];
    bit            merr, done, found;
    int            nst, kind;
    logic [AW-1:0] a, ra;
    logic [DW-1:0] d, fd;
    for (int it = 0; it < 40; it++) begin
      mq_addr.delete(); mq_data.delete(); merr = 1'b0;
      enter_log();
      nst  = $urandom_range(0, 10);
      kind = $urandom_range(0, 5);
      for (int s = 0; s < nst; s++) begin
        repeat ($urandom_range(0, 2)) step();
        a = 32'h100 + 32'($urandom_range(0, 3) * 4);
        d = $urandom;
        log_store(a, d);
        if (mq_addr.size() < DEPTH) begin
          mq_addr.push_back(a); mq_data.push_back(d);
        end else merr = 1'b1;
        ra = 32'h100 + 32'($urandom_range(0, 4) * 4);
        found = 1'b0; fd = '0;
        for (int k = mq_addr.size() - 1; k >= 0; k--)
          if (!found && mq_addr[k] == ra) begin found = 1'b1; fd = mq_data[k]; end
        rd_addr = ra; #1;
        n_checks++;
        if (rd_hit !== found || rd_data !== fd) begin
          n_fail++;
          $display("FAIL rnd_fwd it%0d: addr %h got %b/%h want %b/%h",
                   it, ra, rd_hit, rd_data, found, fd);
        end
      end
      n_checks++;
      if (log_count !== 4'(mq_addr.size()) || commit_err !== merr) begin
        n_fail++;
        $display("FAIL rnd_count it%0d: got %0d/%b want %0d/%b",
                 it, log_count, commit_err, mq_addr.size(), merr);
      end
      log_we = 1'($urandom_range(0, 1));
      log_addr = 32'h10C; log_wdata = $urandom;
      if (kind == 0 || kind == 1) begin
        if (kind == 0) abort = 1'b1; else recovery_mode = 1'b0;
        replay_done = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        abort = 1'b0; replay_done = 1'b0; log_we = 1'b0;
        n_checks++;
        if (log_count !== 4'd0 || mem_we !== 1'b0 || core_hold_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_abort it%0d: got cnt=%0d we=%b hold=%b want 0/0/0",
                   it, log_count, mem_we, core_hold_req);
        end
      end else begin
        if (log_we) begin
          if (mq_addr.size() < DEPTH) begin
            mq_addr.push_back(log_addr); mq_data.push_back(log_wdata);
          end else merr = 1'b1;
        end
        replay_done = 1'b1;
        step();
        replay_done = 1'b0; log_we = 1'b0;
        run_drain(200, 1'b1, done);
        if (merr) begin mq_addr.delete(); mq_data.delete(); end
        n_checks++;
        if (!done || obs_addr.size() != mq_addr.size() || commit_err !== merr) begin
          n_fail++;
          $display("FAIL rnd_drain it%0d: got done=%b n=%0d err=%b want 1/%0d/%b",
                   it, done, obs_addr.size(), commit_err, mq_addr.size(), merr);
        end else begin
          for (int k = 0; k < mq_addr.size(); k++) begin
            n_checks++;
            if (obs_addr[k] !== mq_addr[k] || obs_data[k] !== mq_data[k]) begin
              n_fail++;
              $display("FAIL rnd_write it%0d.%0d: got %h/%h want %h/%h",
                       it, k, obs_addr[k], obs_data[k], mq_addr[k], mq_data[k]);
            end
          end
        end
        step();
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; recovery_mode = 1'b0; log_we = 1'b0; replay_done = 1'b0; abort = 1'b0;
    mem_ready = 1'b0; log_addr = '0; log_wdata = '0; rd_addr = '0;
    test_reset();
    test_basic_commit();
    test_backpressure();
    test_overflow();
    test_abort();
    test_forward();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
